// File: rtl/uart_rx_param_if.sv
// Bundle of the receiver's tick, serial line, flag-clear and result signals.
//
// READY/READY_CLR is a sticky flag, not a valid/ready pipeline handshake.
// READY rises on the edge that completes a word and stays high until READY_CLR
// is seen high on any CLK edge. DATA and the error flags stay stable between
// completions. If a word completes while READY is already high and READY_CLR
// is low, OVERRUN is set and DATA is overwritten anyway.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 CLK_EN;
  logic                 RX;
  logic                 READY_CLR;
  logic [DATA_BITS-1:0] DATA;
  logic                 READY;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 OVERRUN;
  logic                 BUSY;

  // Side that owns the serial line, the tick and the flag clear.
  modport master (
    output CLK_EN, RX, READY_CLR,
    input  DATA, READY, PARITY_ERR, FRAME_ERR, OVERRUN, BUSY
  );

  // Receiver side.
  modport slave (
    input  CLK_EN, RX, READY_CLR,
    output DATA, READY, PARITY_ERR, FRAME_ERR, OVERRUN, BUSY
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// The asynchronous RX line passes through a two-flop synchroniser. A frame
// sequencer then samples it on the external oversample tick (CLK_EN). Every
// bit is decided by a 3-sample majority vote around mid-bit. Start bits that
// do not survive the vote are rejected. Parity and stop bits are checked.
// Results are latched together with READY and OVERRUN.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,   // 5..9
  parameter int OVERSAMPLE = 16,  // even, 8..64
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1    // 1 or 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_param_if.slave        bus,
  output logic [2:0]            state_dbg
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;

  // Sample indices inside one bit time.
  localparam logic [CW-1:0] S_MIDM1 = CW'(MID - 1);
  localparam logic [CW-1:0] S_MID   = CW'(MID);
  localparam logic [CW-1:0] S_MIDP1 = CW'(MID + 1);
  localparam logic [CW-1:0] S_LAST  = CW'(OVERSAMPLE - 1);

  localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Synchroniser.
  logic                 rx_meta;
  logic                 rxs;

  // Frame sequencer.
  state_t               state;
  logic [CW-1:0]        sample;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 v_lo;      // rxs captured at MID-1
  logic                 v_mid;     // rxs captured at MID
  logic [DATA_BITS-1:0] scratch;
  logic                 perr;
  logic                 ferr;

  // Registered results.
  logic [DATA_BITS-1:0] data_q;
  logic                 ready_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 overrun_q;

  // Majority of the three mid-bit samples. The third sample is the live rxs,
  // so the vote is only meaningful on the MID+1 tick.
  logic vote;
  logic ferr_next;
  logic perr_calc;

  assign vote      = (v_lo & v_mid) | (v_lo & rxs) | (v_mid & rxs);
  assign ferr_next = ferr | ~vote;
  assign perr_calc = (^scratch) ^ vote ^ PAR_ODD;

  // Two-flop synchroniser for the asynchronous line, idle-high after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.RX;
      rxs     <= rx_meta;
    end
  end

  // Frame sequencer and result registers. Sequencing moves only on ticks.
  // READY_CLR acts on every edge. A completion in the same cycle overrides it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      sample    <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      v_lo      <= 1'b1;
      v_mid     <= 1'b1;
      scratch   <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.READY_CLR) begin
        ready_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (bus.CLK_EN) begin
        // The first two vote samples are kept in every active state.
        if (state != ST_IDLE) begin
          if (sample == S_MIDM1) v_lo  <= rxs;
          if (sample == S_MID)   v_mid <= rxs;
        end

        case (state)
          ST_IDLE: begin
            // The tick that first sees the line low counts as sample 0.
            if (!rxs) begin
              state  <= ST_START;
              sample <= CW'(1);
              perr   <= 1'b0;
              ferr   <= 1'b0;
            end
          end

          ST_START: begin
            if (sample == S_MIDP1 && vote) begin
              // The line went back high before mid-bit: treat it as noise.
              state  <= ST_IDLE;
              sample <= '0;
            end else if (sample == S_LAST) begin
              state   <= ST_DATA;
              sample  <= '0;
              bit_idx <= '0;
            end else begin
              sample <= sample + CW'(1);
            end
          end

          ST_DATA: begin
            if (sample == S_MIDP1) scratch[bit_idx] <= vote;
            if (sample == S_LAST) begin
              sample <= '0;
              if (bit_idx == B_LAST) begin
                state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                stop_idx <= 1'b0;
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              sample <= sample + CW'(1);
            end
          end

          ST_PARITY: begin
            if (sample == S_MIDP1) perr <= perr_calc;
            if (sample == S_LAST) begin
              state    <= ST_STOP;
              sample   <= '0;
              stop_idx <= 1'b0;
            end else begin
              sample <= sample + CW'(1);
            end
          end

          ST_STOP: begin
            if (sample == S_MIDP1 && stop_idx == STOP_LAST) begin
              // Finish at mid of the last stop bit so that a start edge which
              // follows with no idle gap is still seen from IDLE.
              data_q    <= scratch;
              perr_q    <= perr;
              ferr_q    <= ferr_next;
              ready_q   <= 1'b1;
              overrun_q <= overrun_q | (ready_q & ~bus.READY_CLR);
              state     <= ST_IDLE;
              sample    <= '0;
            end else begin
              if (sample == S_MIDP1) ferr <= ferr_next;
              if (sample == S_LAST) begin
                sample   <= '0;
                stop_idx <= 1'b1;
              end else begin
                sample <= sample + CW'(1);
              end
            end
          end

          default: begin
            state  <= ST_IDLE;
            sample <= '0;
          end
        endcase
      end
    end
  end

  assign bus.DATA       = data_q;
  assign bus.READY      = ready_q;
  assign bus.PARITY_ERR = perr_q;
  assign bus.FRAME_ERR  = ferr_q;
  assign bus.OVERRUN    = overrun_q;
  assign bus.BUSY       = (state != ST_IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param. It runs three receivers side by side, each in its
// own configuration and each with its own reset:
//   u_a : 8N1, 16x
//   u_b : 8 data bits, even parity, 2 stop bits, 16x
//   u_c : 7N1, 8x
// Frames are built bit by bit from plain rules. Expected words go through a
// queue. READY and OVERRUN are predicted by a small flag model.
module tb_uart_rx_param;

  localparam int W       = 32;
  localparam int F_DATA  = 0;
  localparam int F_READY = 1;
  localparam int F_PERR  = 2;
  localparam int F_FERR  = 3;
  localparam int F_OVR   = 4;
  localparam int F_BUSY  = 5;

  logic clk;
  logic clk_en;
  logic rst_a, rst_b, rst_c;
  logic [2:0] st_a, st_b, st_c;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7)) if_c ();

  assign if_a.CLK_EN = clk_en;
  assign if_b.CLK_EN = clk_en;
  assign if_c.CLK_EN = clk_en;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.CLK(clk), .RST(rst_a), .bus(if_a), .state_dbg(st_a));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_b (.CLK(clk), .RST(rst_b), .bus(if_b), .state_dbg(st_b));
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_c (.CLK(clk), .RST(rst_c), .bus(if_c), .state_dbg(st_c));

  // ---------------- clock / reset / tick ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One oversample tick on every second rising edge.
  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk) clk_en = 1'b1;
      @(negedge clk) clk_en = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int last_run[3];
  int run_len[3];
  int rises_c = 0;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] get(input int which, input int field);
    logic [W-1:0] d;
    logic [4:0]   f;
    case (which)
      0: begin
        d = W'(if_a.DATA);
        f = {if_a.BUSY, if_a.OVERRUN, if_a.FRAME_ERR, if_a.PARITY_ERR, if_a.READY};
      end
      1: begin
        d = W'(if_b.DATA);
        f = {if_b.BUSY, if_b.OVERRUN, if_b.FRAME_ERR, if_b.PARITY_ERR, if_b.READY};
      end
      default: begin
        d = W'(if_c.DATA);
        f = {if_c.BUSY, if_c.OVERRUN, if_c.FRAME_ERR, if_c.PARITY_ERR, if_c.READY};
      end
    endcase
    if (field == F_DATA) return d;
    return W'(f[field-1]);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Compares the data word (last expected word in the queue) and all flags.
  task automatic check_frame(input int which, input string tag,
                             input int rdy, input int pe, input int fe, input int ov);
    logic [W-1:0] exp_d;
    exp_d = (exp_q.size() != 0) ? exp_q[$] : '0;
    exp_q.delete();
    check({tag, ".data"},  get(which, F_DATA),  exp_d);
    check({tag, ".ready"}, get(which, F_READY), W'(rdy));
    check({tag, ".perr"},  get(which, F_PERR),  W'(pe));
    check({tag, ".ferr"},  get(which, F_FERR),  W'(fe));
    check({tag, ".ovr"},   get(which, F_OVR),   W'(ov));
  endtask

  task automatic wait_tick;
    do @(posedge clk); while (clk_en !== 1'b1);
  endtask

  task automatic set_rx(input int which, input logic lvl);
    case (which)
      0:       if_a.RX = lvl;
      1:       if_b.RX = lvl;
      default: if_c.RX = lvl;
    endcase
  endtask

  task automatic set_clr(input int which, input logic lvl);
    case (which)
      0:       if_a.READY_CLR = lvl;
      1:       if_b.READY_CLR = lvl;
      default: if_c.READY_CLR = lvl;
    endcase
  endtask

  // Holds the line at lvl for n ticks; entered and left just after a tick.
  task automatic drive(input int which, input logic lvl, input int n);
    set_rx(which, lvl);
    repeat (n) begin
      wait_tick;
      #1;
    end
  endtask

  // READY_CLR held for exactly one edge. That edge is not a tick edge.
  task automatic pulse_clr(input int which);
    set_clr(which, 1'b1);
    @(posedge clk);
    #1;
    set_clr(which, 1'b0);
  endtask

  // Serial frame: start, LSB-first data, optional parity, stop bits, idle.
  // glitch_bit >= 0 flips the line for one tick at mid-bit of that data bit.
  task automatic send_frame(input int which, input logic [8:0] word, input int nbits,
                            input int os, input bit par_en, input logic par_bit,
                            input int nstop, input logic [1:0] stop_lvl,
                            input int glitch_bit, input int idle_after);
    drive(which, 1'b0, os);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        drive(which, word[i], os / 2);
        drive(which, ~word[i], 1);
        drive(which, word[i], os - os / 2 - 1);
      end else begin
        drive(which, word[i], os);
      end
    end
    if (par_en) drive(which, par_bit, os);
    for (int s = 0; s < nstop; s++) drive(which, stop_lvl[s], os);
    drive(which, 1'b1, idle_after);
  endtask

  // Length in ticks of each completed BUSY pulse.
  initial begin
    for (int i = 0; i < 3; i++) begin
      run_len[i]  = 0;
      last_run[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (clk_en) begin
        #1;
        for (int i = 0; i < 3; i++) begin
          if (get(i, F_BUSY) != 0) run_len[i]++;
          else if (run_len[i] != 0) begin
            last_run[i] = run_len[i];
            run_len[i]  = 0;
          end
        end
      end
    end
  end

  // Counts READY rising edges on u_c.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (if_c.READY === 1'b1 && prev === 1'b0) rises_c++;
      prev = if_c.READY;
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [8:0] w;
    logic       pbit;
    logic [1:0] stops;
    int         m_rdy, m_ov, k, pe, fe;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.RX = 1'b1; if_b.RX = 1'b1; if_c.RX = 1'b1;
    if_a.READY_CLR = 1'b0; if_b.READY_CLR = 1'b0; if_c.READY_CLR = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset values.
    check("rst_a.data",  get(0, F_DATA),  0);
    check("rst_a.ready", get(0, F_READY), 0);
    check("rst_a.perr",  get(0, F_PERR),  0);
    check("rst_a.ferr",  get(0, F_FERR),  0);
    check("rst_a.ovr",   get(0, F_OVR),   0);
    check("rst_a.busy",  get(0, F_BUSY),  0);
    check("rst_b.ready", get(1, F_READY), 0);
    check("rst_c.busy",  get(2, F_BUSY),  0);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    wait_tick; #1;
    drive(0, 1'b1, 4);

    // ---- u_a: 8N1 0xA5, completion 153 ticks after the start tick ----
    exp_q.push_back(W'(8'hA5));
    send_frame(0, 9'h0A5, 8, 16, 1'b0, 1'b0, 1, 2'b11, -1, 4);
    check_frame(0, "a_A5", 1, 0, 0, 0);
    check("a_A5.busy_ticks", W'(last_run[0]), 153);

    // READY_CLR on a cycle without a tick.
    pulse_clr(0);
    check("a_clr.ready", get(0, F_READY), 0);
    check("a_clr.data_held", get(0, F_DATA), W'(8'hA5));
    wait_tick; #1;

    // ---- u_a: false start, low for 4 ticks ----
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 20);
    check("a_false.ready", get(0, F_READY), 0);
    check("a_false.busy",  get(0, F_BUSY),  0);
    check("a_false.busy_ticks", W'(last_run[0]), 9);

    // ---- u_a: back-to-back frames with no clear -> overrun ----
    exp_q.push_back(W'(8'h11));
    send_frame(0, 9'h011, 8, 16, 1'b0, 1'b0, 1, 2'b11, -1, 0);
    exp_q.push_back(W'(8'h22));
    send_frame(0, 9'h022, 8, 16, 1'b0, 1'b0, 1, 2'b11, -1, 4);
    check_frame(0, "a_b2b", 1, 0, 0, 1);
    pulse_clr(0);
    check("a_b2b_clr.ready", get(0, F_READY), 0);
    check("a_b2b_clr.ovr",   get(0, F_OVR),   0);
    wait_tick; #1;

    // ---- u_a: READY_CLR coincident with completion ----
    exp_q.push_back(W'(8'h3C));
    send_frame(0, 9'h03C, 8, 16, 1'b0, 1'b0, 1, 2'b11, -1, 6);
    check_frame(0, "a_3C", 1, 0, 0, 0);
    exp_q.push_back(W'(8'h5A));
    k = 0;
    fork
      send_frame(0, 9'h05A, 8, 16, 1'b0, 1'b0, 1, 2'b11, -1, 6);
      begin
        while (get(0, F_BUSY) == 0 && k < 40) begin
          wait_tick; #1;
          k++;
        end
        repeat (152) begin
          wait_tick; #1;
        end
        @(posedge clk); #1;
        if_a.READY_CLR = 1'b1;
        wait_tick; #1;
        if_a.READY_CLR = 1'b0;
      end
    join
    check("a_coinc.start_seen", W'(k < 40), 1);
    check_frame(0, "a_coinc", 1, 0, 0, 0);

    // ---- u_a: random words, random clears and gaps ----
    m_rdy = 1;
    m_ov  = 0;
    for (int i = 0; i < 10; i++) begin
      w = 9'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr(0);
        wait_tick; #1;
        m_rdy = 0;
        m_ov  = 0;
      end
      if (m_rdy != 0) m_ov = 1;
      m_rdy = 1;
      exp_q.push_back(W'(w[7:0]));
      send_frame(0, w, 8, 16, 1'b0, 1'b0, 1, 2'b11, -1, $urandom_range(0, 3));
      check_frame(0, $sformatf("a_rand%0d", i), m_rdy, 0, 0, m_ov);
    end

    // ---- u_b: even parity, 2 stop bits ----
    drive(1, 1'b1, 2);
    exp_q.push_back(W'(8'h37));
    send_frame(1, 9'h037, 8, 16, 1'b1, 1'b0, 2, 2'b11, -1, 16);
    check_frame(1, "b_37_bad", 1, 1, 0, 0);
    check("b_37_bad.busy_ticks", W'(last_run[1]), 185);

    pulse_clr(1); wait_tick; #1;
    exp_q.push_back(W'(8'h37));
    send_frame(1, 9'h037, 8, 16, 1'b1, 1'b1, 2, 2'b11, -1, 16);
    check_frame(1, "b_37_ok", 1, 0, 0, 0);

    // Second stop bit low.
    pulse_clr(1); wait_tick; #1;
    exp_q.push_back(W'(8'hA6));
    send_frame(1, 9'h0A6, 8, 16, 1'b1, 1'b0, 2, 2'b01, -1, 16);
    check_frame(1, "b_stop2", 1, 0, 1, 0);

    // One-tick glitch at mid of data bit 2.
    pulse_clr(1); wait_tick; #1;
    exp_q.push_back(W'(8'h5C));
    send_frame(1, 9'h05C, 8, 16, 1'b1, 1'b0, 2, 2'b11, 2, 16);
    check_frame(1, "b_glitch", 1, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      w     = 9'($urandom_range(0, 255));
      pe    = ($urandom_range(0, 2) == 0) ? 1 : 0;
      stops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      fe    = (stops == 2'b11) ? 0 : 1;
      // Even parity: the correct bit makes the total count of ones even.
      pbit  = 1'(($countones(w[7:0]) + pe) % 2);
      pulse_clr(1); wait_tick; #1;
      exp_q.push_back(W'(w[7:0]));
      send_frame(1, w, 8, 16, 1'b1, pbit, 2, stops, -1, 16);
      check_frame(1, $sformatf("b_rand%0d", i), 1, pe, fe, 0);
    end

    // ---- u_c: 7N1 at 8x, reset in the middle of a frame ----
    drive(2, 1'b1, 2);
    w = 9'h055;
    drive(2, 1'b0, 8);
    for (int i = 0; i < 3; i++) drive(2, w[i], 8);
    drive(2, w[3], 3);
    rst_c = 1'b1;
    set_rx(2, 1'b1);
    wait_tick; #1;
    wait_tick; #1;
    rst_c = 1'b0;
    drive(2, 1'b1, 20);
    check("c_abort.ready", get(2, F_READY), 0);
    check("c_abort.busy",  get(2, F_BUSY),  0);
    check("c_abort.ferr",  get(2, F_FERR),  0);

    exp_q.push_back(W'(7'h2A));
    send_frame(2, 9'h02A, 7, 8, 1'b0, 1'b0, 1, 2'b11, -1, 6);
    check_frame(2, "c_2A", 1, 0, 0, 0);
    check("c_2A.ready_rises", W'(rises_c), 1);
    check("c_2A.busy_ticks", W'(last_run[2]), 69);

    for (int i = 0; i < 4; i++) begin
      w = 9'($urandom_range(0, 127));
      pulse_clr(2); wait_tick; #1;
      exp_q.push_back(W'(w[6:0]));
      send_frame(2, w, 7, 8, 1'b0, 1'b0, 1, 2'b11, -1, $urandom_range(0, 3));
      check_frame(2, $sformatf("c_rand%0d", i), 1, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
